// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame-synchronous
// loading, per-digit decimal points, leading-zero blanking and 16-level PWM.
module seg_scan_ctrl #(
   parameter int unsigned N_DIG      = 4,
   parameter int unsigned F_CLK_HZ   = 50_000_000,
   parameter int unsigned SCAN_HZ    = 1000,
   parameter int unsigned ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*N_DIG-1:0] dat,
   input  logic [N_DIG-1:0]   dp,
   input  logic               load,
   input  logic               blank_lz,
   input  logic [3:0]         bright,
   output logic [N_DIG-1:0]   AN,
   output logic [7:0]         SEG,
   output logic               ce_scan
);

   // DIV must be a multiple of 16 so every brightness step is a whole number of cycles
   localparam int unsigned DIV   = F_CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam int unsigned STEP  = DIV / 16;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIG - 1);
   localparam logic [N_DIG-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [7:0]       SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [4*N_DIG-1:0] stg_dat_q, stg_dat_d, disp_dat_q, disp_dat_d;
   logic [N_DIG-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
   logic [N_DIG-1:0]   an_q, an_d;
   logic [7:0]         seg_q, seg_d;

   logic               ce_c;
   logic               wrap_c;
   logic [3:0]         nib_c;
   logic               dp_bit_c;
   logic               all_zero_c;
   logic               lz_c;
   logic [CNT_W:0]     thr_c;
   logic               on_c;
   logic [6:0]         seg7_c;
   logic [N_DIG-1:0]   an_ah_c;
   logic [7:0]         seg_ah_c;

   // Slot prescaler, digit index, staging and frame-synchronous display update
   always_comb begin
      ce_c       = (cnt_q == CNT_MAX);
      wrap_c     = ce_c && (idx_q == IDX_MAX);
      cnt_d      = ce_c ? '0 : cnt_q + CNT_W'(1);
      idx_d      = idx_q;
      if (ce_c) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
      stg_dat_d  = load ? dat : stg_dat_q;
      stg_dp_d   = load ? dp  : stg_dp_q;
      // commit uses the pre-edge staging value, so a load on the wrap edge waits a frame
      disp_dat_d = wrap_c ? stg_dat_q : disp_dat_q;
      disp_dp_d  = wrap_c ? stg_dp_q  : disp_dp_q;
   end

   // Select the current digit and decide whether it is a leading zero
   always_comb begin
      nib_c      = 4'h0;
      dp_bit_c   = 1'b0;
      all_zero_c = 1'b1;
      lz_c       = 1'b0;
      for (int i = N_DIG - 1; i >= 0; i--) begin
         all_zero_c = all_zero_c && (disp_dat_q[4*i +: 4] == 4'h0);
         if (IDX_W'(i) == idx_q) begin
            nib_c    = disp_dat_q[4*i +: 4];
            dp_bit_c = disp_dp_q[i];
            lz_c     = all_zero_c && (i != 0);
         end
      end
   end

   // Hex decode, PWM gate and output polarity
   always_comb begin
      case (nib_c)
         4'h0: seg7_c = 7'h3F;
         4'h1: seg7_c = 7'h06;
         4'h2: seg7_c = 7'h5B;
         4'h3: seg7_c = 7'h4F;
         4'h4: seg7_c = 7'h66;
         4'h5: seg7_c = 7'h6D;
         4'h6: seg7_c = 7'h7D;
         4'h7: seg7_c = 7'h07;
         4'h8: seg7_c = 7'h7F;
         4'h9: seg7_c = 7'h6F;
         4'hA: seg7_c = 7'h77;
         4'hB: seg7_c = 7'h7C;
         4'hC: seg7_c = 7'h39;
         4'hD: seg7_c = 7'h5E;
         4'hE: seg7_c = 7'h79;
         default: seg7_c = 7'h71;
      endcase
      thr_c    = (CNT_W+1)'((32'(bright) + 32'd1) * STEP);
      on_c     = ({1'b0, cnt_q} < thr_c) && !(blank_lz && lz_c);
      an_ah_c  = on_c ? (N_DIG'(1) << idx_q) : '0;
      seg_ah_c = on_c ? {dp_bit_c, seg7_c} : 8'h00;
      an_d     = (ACTIVE_LOW != 0) ? ~an_ah_c  : an_ah_c;
      seg_d    = (ACTIVE_LOW != 0) ? ~seg_ah_c : seg_ah_c;
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         stg_dat_q  <= '0;
         stg_dp_q   <= '0;
         disp_dat_q <= '0;
         disp_dp_q  <= '0;
         an_q       <= AN_OFF;
         seg_q      <= SEG_OFF;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         stg_dat_q  <= stg_dat_d;
         stg_dp_q   <= stg_dp_d;
         disp_dat_q <= disp_dat_d;
         disp_dp_q  <= disp_dp_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign AN      = an_q;
   assign SEG     = seg_q;
   assign ce_scan = ce_c && !rst;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: N_DIG=4, DIV=16, active-low outputs.
// Expected per-cycle outputs are queued ahead of time and checked at negedge.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] dat = 16'h0000;
   logic [3:0]  dp = 4'h0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  bright = 4'hF;
   logic [3:0]  AN;
   logic [7:0]  SEG;
   logic        ce_scan;

   typedef struct {
      int         at;
      int         p;
      string      tag;
      logic [3:0] an;
      logic [7:0] seg;
      logic       ce;
   } exp_t;

   exp_t sb[$];
   exp_t ck_e;
   int   cyc = 0;
   int   rel = 0;
   int   total = 0;
   int   bad = 0;

   localparam int NOLIM = 100000;

   seg_scan_ctrl #(
      .N_DIG(4), .F_CLK_HZ(16000), .SCAN_HZ(1000), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .dat(dat), .dp(dp), .load(load),
      .blank_lz(blank_lz), .bright(bright),
      .AN(AN), .SEG(SEG), .ce_scan(ce_scan)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: pop every entry due on this cycle and compare
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         ck_e = sb.pop_front();
         total++;
         if (ck_e.at != cyc) begin
            bad++;
            $error("FAIL %s stale p=%0d: due cycle %0d, now %0d", ck_e.tag, ck_e.p, ck_e.at, cyc);
         end else begin
            assert ({AN, SEG, ce_scan} === {ck_e.an, ck_e.seg, ck_e.ce}) else begin
               bad++;
               $error("FAIL %s p=%0d: got AN=%h SEG=%h ce=%b, want AN=%h SEG=%h ce=%b",
                      ck_e.tag, ck_e.p, AN, SEG, ce_scan, ck_e.an, ck_e.seg, ck_e.ce);
            end
         end
      end
   end

   // Queue one frame of expectations; segs holds active-low patterns, digit 0 in the low byte
   task automatic push_frame(input int f, input string tag, input logic [31:0] segs,
                             input logic [3:0] vis, input int lit_n, input int limit);
      exp_t       e;
      logic [3:0] oh;
      logic       on;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 16; c++) begin
            e.p = f*64 + d*16 + c;
            if (e.p <= limit) begin
               oh    = 4'b0001 << d;
               on    = vis[d] && (c < lit_n);
               e.at  = rel + e.p;
               e.tag = tag;
               e.an  = on ? ~oh : 4'hF;
               e.seg = on ? segs[8*d +: 8] : 8'hFF;
               e.ce  = (c == 14);
               sb.push_back(e);
            end
         end
      end
   endtask

   task automatic goto(input int p);
      while (cyc < rel + p) @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      total++;
      assert ({AN, SEG, ce_scan} === {4'hF, 8'hFF, 1'b0}) else begin
         bad++;
         $error("FAIL %s: got AN=%h SEG=%h ce=%b, want AN=f SEG=ff ce=0", tag, AN, SEG, ce_scan);
      end
   endtask

   initial begin
      // Reset held three cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_idle("reset_hold");
      end
      rst = 1'b0;
      rel = cyc + 1;
      push_frame(0, "walk_zero", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'hF, 16, NOLIM);

      // Mid-frame load; old frame unchanged, new data next frame
      goto(20);
      load = 1'b1; dat = 16'h1A2F; dp = 4'b0100;
      push_frame(1, "decode", {8'hF9, 8'h08, 8'hA4, 8'h8E}, 4'hF, 16, NOLIM);
      goto(21);
      load = 1'b0;

      // Load on the frame-wrap edge is staged only
      goto(126);
      load = 1'b1; dat = 16'h0005; dp = 4'b0000;
      push_frame(2, "wrap_load_hold", {8'hF9, 8'h08, 8'hA4, 8'h8E}, 4'hF, 16, NOLIM);
      push_frame(3, "wrap_load_show", {8'hC0, 8'hC0, 8'hC0, 8'h92}, 4'hF, 16, NOLIM);
      goto(127);
      load = 1'b0;

      // Leading-zero blanking
      goto(200);
      load = 1'b1; dat = 16'h0050;
      push_frame(4, "lz_0050", {8'hC0, 8'hC0, 8'h92, 8'hC0}, 4'b0011, 16, NOLIM);
      goto(201);
      load = 1'b0;
      goto(255);
      blank_lz = 1'b1;
      goto(260);
      load = 1'b1; dat = 16'h0000;
      push_frame(5, "lz_all_zero", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b0001, 16, NOLIM);
      goto(261);
      load = 1'b0;

      // PWM levels
      goto(330);
      load = 1'b1; dat = 16'h1234;
      goto(331);
      load = 1'b0;
      goto(383);
      blank_lz = 1'b0; bright = 4'd3;
      push_frame(6, "pwm_3", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF, 4, NOLIM);
      goto(447);
      bright = 4'd0;
      push_frame(7, "pwm_0", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF, 1, NOLIM);
      goto(511);
      bright = 4'd15;
      push_frame(8, "pwm_15", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF, 16, NOLIM);
      push_frame(9, "pre_reset", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF, 16, 616);

      // Reset sampled with idx=2, cnt=9
      goto(616);
      rst = 1'b1;
      goto(617);
      chk_idle("reset_mid");
      goto(618);
      chk_idle("reset_mid_hold");
      rst = 1'b0;
      rel = cyc + 1;
      push_frame(0, "post_reset", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'hF, 16, NOLIM);
      push_frame(1, "post_reset_stg", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'hF, 16, NOLIM);

      goto(128);
      repeat (2) @(negedge clk);
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL drain: %0d entries left, want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment display controller for the board's LED display. It scans N_DIG digits from a packed hex word and generates its own scan strobe from the system clock. It adds frame-synchronous (tear-free) data loading, per-digit decimal points, leading-zero blanking and 16-level PWM brightness. It sits between user logic and the AN/SEG pins and replaces the fixed 4-digit display driver.

## Interface

Parameters:
- N_DIG, 4: number of digits scanned (1..8).
- F_CLK_HZ, 50_000_000: clk frequency.
- SCAN_HZ, 1000: digit-slot rate. DIV = F_CLK_HZ/SCAN_HZ; DIV must be ≥ 16 and divisible by 16.
- ACTIVE_LOW, 1: when 1, AN and SEG are driven active-low; when 0, active-high.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- dat, in, 4*N_DIG: hex nibbles; nibble i (dat[4i+3:4i]) drives digit i, and digit 0 is rightmost.
- dp, in, N_DIG: decimal point for digit i.
- load, in, 1: stage dat/dp on this edge.
- blank_lz, in, 1: enable leading-zero blanking.
- bright, in, 4: duty level; 0 = 1/16, 15 = full.
- AN, out, N_DIG: digit enables, one-hot active.
- SEG, out, 8: SEG[0..6] = segments a..g, SEG[7] = dp.
- ce_scan, out, 1: one-cycle strobe at the end of each digit slot.

## Operation

- **Prescaler `cnt`:**
  - Runs 0..DIV-1, then wraps to 0.
  - ce_scan = 1 for exactly the cycle where cnt == DIV-1.
- **Digit index `idx`:**
  - Runs 0..N_DIG-1.
  - Increments on the edge where ce_scan = 1 and wraps N_DIG-1 → 0.
  - The edge where ce_scan = 1 and idx == N_DIG-1 is the *frame wrap*.
- **Staging registers:** when load = 1, stg_dat ← dat and stg_dp ← dp. Loads are sampled every cycle and the last one before a frame wrap wins.
- **Display registers:**
  - disp_dat ← stg_dat and disp_dp ← stg_dp only at frame wrap.
  - A load coinciding with the frame-wrap edge is staged only. It is committed at the following frame wrap.
- **Leading-zero blanking:**
  - Applies when blank_lz = 1.
  - Digit i (i ≥ 1) is blanked iff disp_dat nibbles i..N_DIG-1 are all 0.
  - Digit 0 is never blanked.
  - dp does not inhibit blanking.
- **PWM:**
  - thr = ((bright+1)*DIV)/16.
  - The slot is lit while cnt < thr; otherwise AN is all inactive.
- **Decoder:** standard hex patterns as internal active-high values (bit0 = a).
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F
  - 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07
  - 8 = 0x7F, 9 = 0x6F, A = 0x77, b = 0x7C
  - C = 0x39, d = 0x5E, E = 0x79, F = 0x71
  - SEG[7] = disp_dp[idx].
- **Output formation:**
  - Active-high value: AN = (1<<idx) when lit and not blanked, else 0.
  - SEG = pattern when lit and not blanked, else 0.
  - Both are inverted when ACTIVE_LOW = 1.
  - AN and SEG are registered.
- **Reset:**
  - cnt, idx, stg_*, and disp_* are cleared to 0.
  - AN and SEG go to their inactive level (all ones when ACTIVE_LOW = 1).
  - ce_scan = 0.
  - Reset mid-frame aborts the frame; the first slot after release is digit 0 with cnt = 0.

## Timing

- AN and SEG have a 1-cycle latency from (cnt, idx, disp_*). A slot's outputs are therefore visible for DIV cycles, offset by 1 cycle.
- ce_scan is combinational from cnt and has no added latency. It is high during the cycle before idx changes.
- load → visible: load edge, then the next frame wrap, then +1 cycle on AN/SEG. Worst case is N_DIG*DIV+1 cycles.
- A bright change takes effect on the next cycle (no frame sync).
- A blank_lz change takes effect on the next cycle.
- In the first cycle after reset release, the registered outputs still show the inactive level.

## Test plan

Bench configuration for all scenarios: N_DIG = 4, F_CLK_HZ = 16000, SCAN_HZ = 1000 (DIV = 16), ACTIVE_LOW = 1.

1. **Reset values.** Assert rst for 3 cycles, then release.
   - While rst is held: AN = 4'hF, SEG = 8'hFF, ce_scan = 0.
   - After release: ce_scan pulses every 16 cycles, and the AN low bit walks 0 → 1 → 2 → 3 → 0.
2. **Decode and tear-free load.** bright = 15, blank_lz = 0. Pulse load with dat = 16'h1A2F, dp = 4'b0100 mid-frame.
   - The old frame completes unchanged.
   - In the next frame, AN = 4'b1110 with SEG = 8'h8E (F); then AN = 4'b1101 with SEG = 8'hA4 (2).
   - Then AN = 4'b1011 with SEG = 8'h08 (A plus dp); then AN = 4'b0111 with SEG = 8'hF9 (1).
3. **Load on the frame-wrap edge.** Load 16'h0005 exactly on the wrap edge.
   - Not displayed in the frame that follows.
   - Displayed from the following frame onward.
4. **Leading-zero blanking.** dat = 16'h0050, blank_lz = 1.
   - Digits 3 and 2 keep AN at 4'hF for their whole slots.
   - Digits 1 and 0 show 5 and 0.
   - With dat = 0, only digit 0 shows 0 (SEG = 8'hC0).
5. **PWM.** bright = 3.
   - Each digit is active for exactly 4 of its 16 cycles, from slot start (+1 latency).
   - bright = 0 gives 1 cycle per slot.
   - bright = 15 gives all 16 cycles.
6. **Reset mid-slot.** Assert rst with idx = 2 and cnt = 9.
   - Outputs go inactive on the next edge; stg/disp clear.
   - After release, digit 0 shows 0 and the first ce_scan arrives 16 cycles later.
